// File: rtl/prog_mem_arb_pkg.sv
// rtl/prog_mem_arb_pkg.sv - shared types and defaults for the program-memory arbiter
package prog_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 255;
    localparam int WAIT_W          = 8;

endpackage

// File: rtl/prog_mem_fetch_buf.sv
// rtl/prog_mem_fetch_buf.sv - one-entry fetch buffer, built only with PROG_MEM_ARB_FETCH_BUF_EN
`ifdef PROG_MEM_ARB_FETCH_BUF_EN
module prog_mem_fetch_buf #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic              valid;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // A flush in the lookup cycle already counts as invalidated.
    assign hit      = valid && !flush && (lookup_addr == addr_q);
    assign hit_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            addr_q <= load_addr;
            data_q <= load_data;
        end
    end

endmodule
`endif

// File: rtl/prog_mem_arbiter.sv
// rtl/prog_mem_arbiter.sv - round-robin fetch/data arbiter for one program memory; optional PROG_MEM_ARB_FETCH_BUF_EN
module prog_mem_arbiter
    import prog_mem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_valid,
    output logic [DATA_W-1:0] a_data,
    output logic              a_err,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_valid,
    output logic [DATA_W-1:0] b_data,
    output logic              b_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush_in
);

    localparam logic [WAIT_W:0] TIMEOUT_LIM = (WAIT_W+1)'(TIMEOUT_CYC);

    state_t            state, state_nx;
    req_id_t           grant, grant_nx, last_served;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W:0]   wait_inc;
    logic              timeout;
    logic              a_pick;
    logic              buf_hit;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] resp_data;

`ifdef PROG_MEM_ARB_FETCH_BUF_EN
    logic buf_load;
    assign buf_load = (state == BUSY) && (grant == REQ_A) && mem_rvalid;

    prog_mem_fetch_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fetch_buf (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .flush      (flush_in),
        .load       (buf_load),
        .load_addr  (mem_addr),
        .load_data  (mem_rdata),
        .lookup_addr(a_addr),
        .hit        (buf_hit),
        .hit_data   (buf_data)
    );
`else
    logic unused_flush;
    assign unused_flush = flush_in;
    assign buf_hit      = 1'b0;
    assign buf_data     = '0;
`endif

    assign wait_inc  = {1'b0, wait_cnt} + {{WAIT_W{1'b0}}, 1'b1};
    assign timeout   = (wait_inc >= TIMEOUT_LIM);
    // A wins unless B also asks and A was the one served last.
    assign a_pick    = a_req && (!b_req || (last_served == REQ_B));
    assign resp_data = mem_rvalid ? mem_rdata : '0;

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        case (state)
            IDLE: begin
                if (a_pick) begin
                    grant_nx = REQ_A;
                    state_nx = buf_hit ? RESP : BUSY;
                end else if (b_req) begin
                    grant_nx = REQ_B;
                    state_nx = BUSY;
                end
            end
            BUSY:    if (mem_rvalid || timeout) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            grant       <= REQ_A;
            last_served <= REQ_B;
            wait_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            a_valid     <= 1'b0;
            a_data      <= '0;
            a_err       <= 1'b0;
            b_valid     <= 1'b0;
            b_data      <= '0;
            b_err       <= 1'b0;
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            a_err   <= 1'b0;
            b_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_nx == BUSY) begin
                        last_served <= grant_nx;
                        wait_cnt    <= '0;
                        mem_req     <= 1'b1;
                        mem_addr    <= (grant_nx == REQ_A) ? a_addr : b_addr;
                    end else if (state_nx == RESP) begin
                        last_served <= REQ_A;
                        a_valid     <= 1'b1;
                        a_data      <= buf_data;
                    end
                end
                BUSY: begin
                    wait_cnt <= wait_inc[WAIT_W-1:0];
                    if (state_nx == RESP) begin
                        mem_req  <= 1'b0;
                        mem_addr <= '0;
                        if (grant == REQ_A) begin
                            a_valid <= 1'b1;
                            a_data  <= resp_data;
                            a_err   <= !mem_rvalid;
                        end else begin
                            b_valid <= 1'b1;
                            b_data  <= resp_data;
                            b_err   <= !mem_rvalid;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// tb/tb_prog_mem_arbiter.sv - randomized bench with transaction-level reference model; honours PROG_MEM_ARB_FETCH_BUF_EN
module tb_prog_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef PROG_MEM_ARB_FETCH_BUF_EN
    localparam bit FB = 1'b1;
`else
    localparam bit FB = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          a_req, b_req, a_valid, b_valid, a_err, b_err;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [DW-1:0] a_data, b_data, mem_rdata;
    logic          mem_req, mem_rvalid, flush_in;

    always #5 clk_in = ~clk_in;

    prog_mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_err     (a_err),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_err     (b_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .flush_in  (flush_in)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    bit            m_last_a;
    logic [DW-1:0] m_a_data, m_b_data;
    bit            m_buf_valid;
    logic [AW-1:0] m_buf_addr;
    logic [DW-1:0] m_buf_data;
    bit            a_pend, b_pend;
    logic [AW-1:0] a_paddr, b_paddr;

    task automatic model_reset();
        m_last_a    = 1'b0;
        m_a_data    = '0;
        m_b_data    = '0;
        m_buf_valid = 1'b0;
        a_pend      = 1'b0;
        b_pend      = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_a_valid"}, a_valid, 0);
        chk({tag, "_b_valid"}, b_valid, 0);
    endtask

    // d: BUSY cycle index at which memory answers (>= TO means never)
    task automatic run_txn(input int d, input logic [DW-1:0] rd);
        bit            win_a, hit, busy, exp_err;
        logic [AW-1:0] waddr;
        logic [DW-1:0] exp_data;
        int            exp_n;
        win_a = a_pend && (!b_pend || !m_last_a);
        hit   = FB && win_a && m_buf_valid && (m_buf_addr == a_paddr);
        waddr = win_a ? a_paddr : b_paddr;
        if (hit) begin
            exp_n = 1; exp_data = m_buf_data; exp_err = 1'b0;
        end else if (d < TO) begin
            exp_n = d + 2; exp_data = rd; exp_err = 1'b0;
        end else begin
            exp_n = TO + 1; exp_data = '0; exp_err = 1'b1;
        end

        @(negedge clk_in);
        check_quiet("idle");
        flush_in   = 1'b0;
        a_req      = a_pend;  a_addr = a_paddr;
        b_req      = b_pend;  b_addr = b_paddr;
        mem_rvalid = 1'($urandom % 2);
        mem_rdata  = $urandom;

        for (int n = 1; n <= exp_n; n++) begin
            @(negedge clk_in);
            busy = !hit && (n < exp_n);
            chk("mem_req", mem_req, busy);
            chk("mem_addr", mem_addr, busy ? waddr : '0);
            if (n < exp_n) begin
                chk("early_a_valid", a_valid, 0);
                chk("early_b_valid", b_valid, 0);
            end else begin
                if (win_a) m_a_data = exp_data;
                else       m_b_data = exp_data;
                chk("a_valid", a_valid, win_a);
                chk("b_valid", b_valid, !win_a);
                chk("a_err", a_err, win_a && exp_err);
                chk("b_err", b_err, !win_a && exp_err);
                chk("a_data", a_data, m_a_data);
                chk("b_data", b_data, m_b_data);
                if (win_a) begin
                    a_pend = 1'b0; m_last_a = 1'b1;
                    if (FB && !hit && !exp_err) begin
                        m_buf_valid = 1'b1; m_buf_addr = a_paddr; m_buf_data = rd;
                    end
                end else begin
                    b_pend = 1'b0; m_last_a = 1'b0;
                end
                a_req = 1'b0;
                b_req = 1'b0;
            end
            if (busy) begin
                mem_rvalid = (n - 1 == d);
                mem_rdata  = (n - 1 == d) ? rd : $urandom;
            end else begin
                mem_rvalid = 1'($urandom % 2);
                mem_rdata  = $urandom;
            end
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk_in);
        check_quiet("flush");
        flush_in   = 1'b1;
        mem_rvalid = 1'b0;
        if (FB) m_buf_valid = 1'b0;
    endtask

    task automatic reset_mid_busy();
        a_pend = 1'b0;
        @(negedge clk_in);
        check_quiet("rst_pre");
        flush_in = 1'b0; mem_rvalid = 1'b0;
        b_req = 1'b1; b_addr = 16'h0abc; a_req = 1'b0;
        @(negedge clk_in);
        chk("rst_busy_mem_req", mem_req, 1);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk("rst_async_mem_req", mem_req, 0);
        chk("rst_async_mem_addr", mem_addr, 0);
        b_req = 1'b0;
        @(negedge clk_in);
        rst_n_in   = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_aaaa;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            check_quiet("rst_after");
        end
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        mem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n_in = 1'b0;
        a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; flush_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_quiet("reset");
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_a_data", a_data, 0);
        chk("reset_b_data", b_data, 0);
        chk("reset_a_err", a_err, 0);
        chk("reset_b_err", b_err, 0);
        rst_n_in = 1'b1;

        // both held after reset: A, B, A, B
        for (int k = 0; k < 4; k++) begin
            if (!a_pend) begin a_pend = 1'b1; a_paddr = 16'h0100 + 16'(k); end
            if (!b_pend) begin b_pend = 1'b1; b_paddr = 16'h0200 + 16'(k); end
            run_txn(1, $urandom);
        end
        a_pend = 1'b0; b_pend = 1'b0;

        a_pend = 1'b1; a_paddr = 16'h0010;
        run_txn(0, 32'hdeadbeef);

        b_pend = 1'b1; b_paddr = 16'h0030;
        run_txn(TO + 3, 32'h1111_2222);

`ifdef PROG_MEM_ARB_FETCH_BUF_EN
        a_pend = 1'b1; a_paddr = 16'h0020; run_txn(2, 32'hcafe_0020);
        a_pend = 1'b1; a_paddr = 16'h0020; run_txn(0, 32'h0bad_0bad);
        pulse_flush();
        a_pend = 1'b1; a_paddr = 16'h0020; run_txn(1, 32'hbeef_0020);
`endif

        reset_mid_busy();

        for (int i = 0; i < 300; i++) begin
            if (!a_pend && ($urandom % 10 < 6)) begin
                a_pend = 1'b1; a_paddr = 16'h0020 + 16'($urandom % 4);
            end
            if (!b_pend && ($urandom % 10 < 6)) begin
                b_pend = 1'b1; b_paddr = 16'($urandom);
            end
            if (!a_pend && !b_pend) begin
                b_pend = 1'b1; b_paddr = 16'($urandom);
            end
            run_txn(int'($urandom % 6), $urandom);
            if ($urandom % 8 == 0) pulse_flush();
        end

        @(negedge clk_in);
        check_quiet("final");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
